// File: rtl/gate_tt_pkg.sv
// Shared types and constants for the gate truth-table scanner.
package gate_tt_pkg;

  // Scanner sequencing states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Truth-table index, {a,b}.
  typedef logic [1:0] idx_t;

  localparam idx_t IDX_FIRST = 2'd0;
  localparam idx_t IDX_LAST  = 2'd3;

  // Expected truth vectors, bit idx holds the gate output for {a,b} = idx.
  localparam logic [3:0] EXP_AND = 4'b1000;
  localparam logic [3:0] EXP_OR  = 4'b1110;
  localparam logic [3:0] EXP_NOT = 4'b0011;

  // Number of gates whose captured vector differs from its expected vector.
  function automatic logic [1:0] mismatch_count(input logic [3:0] and_v,
                                                 input logic [3:0] or_v,
                                                 input logic [3:0] not_v);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (and_v != EXP_AND) cnt = cnt + 2'd1;
    if (or_v  != EXP_OR)  cnt = cnt + 2'd1;
    if (not_v != EXP_NOT) cnt = cnt + 2'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable 4-bit down-counter with a zero flag; paces how long each input
// combination is held before the gate outputs are sampled.
module settle_timer
  import gate_tt_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  // Counter register: load has priority over decrement, saturates at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/gate_tt_scanner.sv
// Drives the gate block through all four {a,b} combinations, captures the
// AND/OR/NOT responses into truth vectors and grades them against the
// expected tables.
module gate_tt_scanner
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1  // hold cycles per combination, 1..15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_a_out,
  output logic       o_b_out,
  input  logic       i_and_in,
  input  logic       i_or_in,
  input  logic       i_not_in,
  output logic [3:0] o_and_vec,
  output logic [3:0] o_or_vec,
  output logic [3:0] o_not_vec,
  output logic       o_done,
  output logic       o_pass,
  output logic [1:0] o_err_cnt
);

  localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

  state_e     r_state;
  state_e     w_state_d;
  idx_t       r_idx;
  idx_t       w_idx_d;
  logic [3:0] r_and_vec;
  logic [3:0] w_and_d;
  logic [3:0] r_or_vec;
  logic [3:0] w_or_d;
  logic [3:0] r_not_vec;
  logic [3:0] w_not_d;
  logic       r_pass;
  logic       w_pass_d;
  logic [1:0] r_err_cnt;
  logic [1:0] w_err_d;
  logic       r_busy;
  logic       w_busy_d;
  logic       r_done;
  logic       w_done_d;
  logic       w_accept;
  logic       w_load;
  logic       w_dec;
  logic       w_zero;

  settle_timer u_settle_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (LP_RELOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next-state, capture and grading logic.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_and_d   = r_and_vec;
    w_or_d    = r_or_vec;
    w_not_d   = r_not_vec;
    w_pass_d  = r_pass;
    w_err_d   = r_err_cnt;
    w_done_d  = 1'b0;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_dec     = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_accept = i_start;
      end
      StDrive: begin
        if (!w_zero) begin
          w_dec = 1'b1;
        end else begin
          w_and_d[r_idx] = i_and_in;
          w_or_d[r_idx]  = i_or_in;
          w_not_d[r_idx] = i_not_in;
          if (r_idx == IDX_LAST) begin
            // Grade on the same edge as the final capture, including it.
            w_state_d = StDone;
            w_done_d  = 1'b1;
            w_err_d   = mismatch_count(w_and_d, w_or_d, w_not_d);
            w_pass_d  = (w_err_d == 2'd0);
          end else begin
            w_idx_d = r_idx + 2'd1;
            w_load  = 1'b1;
          end
        end
      end
      StDone: begin
        // The exit edge from DONE is the first IDLE edge: a start seen here
        // begins the next scan, giving a 4*SETTLE+1 cycle scan period.
        w_state_d = StIdle;
        w_idx_d   = IDX_FIRST;
        w_accept  = i_start;
      end
      default: begin
        w_state_d = StIdle;
        w_idx_d   = IDX_FIRST;
      end
    endcase

    if (w_accept) begin
      w_state_d = StDrive;
      w_idx_d   = IDX_FIRST;
      w_and_d   = 4'd0;
      w_or_d    = 4'd0;
      w_not_d   = 4'd0;
      w_pass_d  = 1'b0;
      w_err_d   = 2'd0;
      w_load    = 1'b1;
    end

    w_busy_d = (w_state_d != StIdle);
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_idx     <= IDX_FIRST;
      r_and_vec <= 4'd0;
      r_or_vec  <= 4'd0;
      r_not_vec <= 4'd0;
      r_pass    <= 1'b0;
      r_err_cnt <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_and_vec <= w_and_d;
      r_or_vec  <= w_or_d;
      r_not_vec <= w_not_d;
      r_pass    <= w_pass_d;
      r_err_cnt <= w_err_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  // The index register doubles as the gate drive: 00 in IDLE, 11 in DONE.
  assign o_a_out   = r_idx[1];
  assign o_b_out   = r_idx[0];
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_and_vec = r_and_vec;
  assign o_or_vec  = r_or_vec;
  assign o_not_vec = r_not_vec;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: doc/gate_tt_scanner.md
# gate_tt_scanner

Sequencing stage that sits directly upstream and downstream of the mux-built logic-gate block. On a start pulse it drives the gate block's `a`/`b` inputs through all four combinations, samples the returned AND/OR/NOT outputs after a programmable settle time, and assembles a 4-bit truth vector per gate. It then compares each vector against the expected truth table and reports pass/fail plus a mismatch count. It is the self-check harness stage used when the gate block is instantiated in hardware.

## Interface
- `SETTLE`, default 1, cycles each input combination is held before sampling; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request a scan; accepted only in IDLE.
- `busy`  out  1  high from the cycle after acceptance until `done` deasserts.
- `a_out`  out  1  drives gate block input `a`.
- `b_out`  out  1  drives gate block input `b`.
- `and_in`  in  1  gate block AND output.
- `or_in`  in  1  gate block OR output.
- `not_in`  in  1  gate block NOT-a output.
- `and_vec`  out  4  captured AND truth vector.
- `or_vec`  out  4  captured OR truth vector.
- `not_vec`  out  4  captured NOT truth vector.
- `done`  out  1  one-cycle pulse when results are final.
- `pass`  out  1  all three vectors match the expected values.
- `err_cnt`  out  2  number of mismatching gates, 0..3.

## Operation
- Vector index `idx` is {a,b}: idx 0=00, 1=01, 2=10, 3=11. Bit `idx` of each vector holds the gate output sampled for that combination.
- Expected vectors:
  - AND = 4'b1000
  - OR = 4'b1110
  - NOT a = 4'b0011
- FSM states: IDLE, DRIVE, DONE.
- **IDLE.** `a_out`=`b_out`=0 and `busy`=0. When `start`=1 at an edge:
  - clear all vectors, `pass` and `err_cnt`;
  - set `idx`=0 and the settle counter to SETTLE-1;
  - go to DRIVE.
- **DRIVE.** `{a_out,b_out}` = `idx`. On each edge:
  - If the counter is nonzero, decrement it.
  - Otherwise capture `and_in`/`or_in`/`not_in` into bit `idx`.
  - If `idx`=3, go to DONE. Otherwise increment `idx` and reload the counter.
- **DONE.** Lasts one cycle. `done`=1 and `busy`=1, with `{a_out,b_out}` held at 11. Then go to IDLE.
- `pass` and `err_cnt` are registered on the same edge as the idx-3 capture, and include that last sample.
- Vectors, `pass` and `err_cnt` hold their values until the next accepted start.
- `start` during DRIVE or DONE is ignored. It is not queued.
- `start` held high continuously re-triggers: a new scan is accepted at the first IDLE edge.

## Timing
- Reset (`rst_n`=0 at an edge) forces IDLE from any state, including mid-scan. All outputs go to 0: `busy`, `done`, `pass`, `err_cnt`, all vectors, `a_out`, `b_out`.
- Start accepted at edge E0, with E0 = 0. After E0:
  - `busy`=1 and `{a_out,b_out}`=00.
  - Combination k is driven from edge E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE.
  - `done` is high from edge E0+4·SETTLE to edge E0+4·SETTLE+1.
- With SETTLE=1, `done` rises 4 cycles after the start edge. The next start can be accepted at E0+4·SETTLE+1 at the earliest; the scan-to-scan period is 4·SETTLE+1 cycles.
- The gate block is combinational, so SETTLE=1 is sufficient. Larger values cover registered or remote gate implementations.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `gate_tt_pkg` holds:
  - the FSM state enum;
  - `EXP_AND`, `EXP_OR`, `EXP_NOT` localparams;
  - a 2-bit index typedef.
- Natural sub-module: `settle_timer`, a loadable 4-bit down-counter with a zero flag.
- The gate block itself is not instantiated here. The top-level testbench connects `a_out`/`b_out` to it and returns its outputs on `and_in`/`or_in`/`not_in`.

## Test plan
- **Connected to a correct gate block, SETTLE=1, start pulse at cycle 0.**
  - `done` at cycle 4.
  - `and_vec`=1000, `or_vec`=1110, `not_vec`=0011.
  - `pass`=1, `err_cnt`=0.
- **`and_in` stuck at 1.**
  - `and_vec`=1111.
  - `pass`=0, `err_cnt`=1.
- **All three inputs tied to 0.**
  - All vectors 0000.
  - `err_cnt`=3.
- **SETTLE=3.**
  - `{a_out,b_out}` holds each of 00, 01, 10, 11 for exactly 3 cycles.
  - `done` at cycle 12.
  - Extra `start` pulses at cycles 5 and 12 are ignored; `busy` stays 1 through cycle 12.
- **`rst_n`=0 at cycle 2 of a scan.** From the next cycle:
  - IDLE, all outputs 0, no `done`.
  - A following start completes a normal passing scan.
- **`start` held high for 20 cycles, SETTLE=1.**
  - `done` pulses at cycles 4, 9, 14 and 19.
  - Results are valid and cleared between scans.
